// File: rtl/pif_cmd_decoder.sv
// pif_cmd_decoder
// Decodes the byte stream received by the EFB I2C slave. Each byte is
// {tag[1:0], payload[5:0]}: an A_ADDR tag loads the register pointer and a
// D_ADDR tag writes the addressed register, then advances the pointer.
// Tag 2'b11 is reserved; it parks the transaction in DISCARD until the
// next START or STOP. The register bank holds the ID, a scratch register,
// the LED mode and a status/error register.
//
// Optional feature: define PIF_CMDDEC_READBACK_EN to enable the readback
// path (RD_REQ -> TX_VALID/TX_BYTE). When it is undefined, TX_VALID and
// TX_BYTE are held at 0 and RD_REQ has no effect.
//
// Ports:
//   CLK, GSRn          clock, async active-low reset
//   I2C_START/STOP     bus condition pulses
//   RX_VALID, RX_BYTE  received byte
//   RD_REQ             slave wants the next transmit byte
//   TX_VALID, TX_BYTE  readback byte, one cycle after RD_REQ
//   WR_STROBE/ADDR/DATA accepted register write, one cycle after RX_VALID
//   LED_MODE           register 2 bits [1:0]
//   ERR                sticky error flag
`ifndef A_ADDR
`define A_ADDR 2'b01
`endif
`ifndef D_ADDR
`define D_ADDR 2'b10
`endif
`ifndef I2C_DATA_BITS
`define I2C_DATA_BITS 6
`endif

module pif_cmd_decoder #(
  parameter int          REG_COUNT      = 8,
  parameter logic [5:0]  ID_VALUE       = 6'h2A,
  parameter logic [1:0]  LED_RESET_MODE = 2'd0
) (
  input  logic       CLK,
  input  logic       GSRn,
  input  logic       I2C_START,
  input  logic       I2C_STOP,
  input  logic       RX_VALID,
  input  logic [7:0] RX_BYTE,
  input  logic       RD_REQ,
  output logic [7:0] TX_BYTE,
  output logic       TX_VALID,
  output logic       WR_STROBE,
  output logic [5:0] WR_ADDR,
  output logic [5:0] WR_DATA,
  output logic [1:0] LED_MODE,
  output logic       ERR
);

  localparam int         IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [6:0] RC = 7'(REG_COUNT);

  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

  state_t     state;
  logic [5:0] ptr;
  logic [5:0] regs [REG_COUNT];  // entries 0 and 3 are never written
  logic [5:0] err_cnt;

  logic [1:0] tag;
  logic [5:0] payload;
  logic       in_range;
  logic       writable;
  logic [IW-1:0] idx;

  assign tag      = RX_BYTE[7:6];
  assign payload  = RX_BYTE[`I2C_DATA_BITS-1:0];
  assign in_range = {1'b0, ptr} < RC;
  assign writable = in_range && (ptr != 6'd0) && (ptr != 6'd3);
  assign idx      = ptr[IW-1:0];
  assign LED_MODE = regs[2][1:0];

`ifdef PIF_CMDDEC_READBACK_EN
  logic [5:0] rd_val;

  always_comb begin
    rd_val = regs[idx];
    if (ptr == 6'd0)      rd_val = ID_VALUE;
    else if (ptr == 6'd3) rd_val = {err_cnt[4:0], ERR};
  end
`else
  logic unused_rd_req;
  assign unused_rd_req = RD_REQ;
  assign TX_VALID      = 1'b0;
  assign TX_BYTE       = 8'h00;
`endif

  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      state     <= IDLE;
      ptr       <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      regs[2]   <= {4'b0, LED_RESET_MODE};
      err_cnt   <= '0;
      ERR       <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
`ifdef PIF_CMDDEC_READBACK_EN
      TX_VALID  <= 1'b0;
      TX_BYTE   <= '0;
`endif
    end else begin
      WR_STROBE <= 1'b0;
`ifdef PIF_CMDDEC_READBACK_EN
      TX_VALID  <= 1'b0;
`endif
      // A received byte takes precedence over a read request in the same cycle.
      if (RX_VALID) begin
        if (state == ACTIVE) begin
          if (tag == `A_ADDR) begin
            ptr <= payload;
          end else if (tag == `D_ADDR) begin
            if (writable) begin
              regs[idx] <= payload;
              WR_STROBE <= 1'b1;
              WR_ADDR   <= ptr;
              WR_DATA   <= payload;
              // all-ones to the scratch register acknowledges errors
              if (ptr == 6'd1 && payload == 6'h3F) begin
                ERR     <= 1'b0;
                err_cnt <= '0;
              end
            end else begin
              ERR <= 1'b1;
              if (err_cnt != 6'h3F) err_cnt <= err_cnt + 6'd1;
            end
            ptr <= ptr + 6'd1;
          end else if (tag == 2'b11) begin
            state <= DISCARD;
          end
        end
`ifdef PIF_CMDDEC_READBACK_EN
      end else if (RD_REQ) begin
        TX_VALID <= 1'b1;
        if (state == ACTIVE) begin
          TX_BYTE <= in_range ? {2'b00, rd_val} : 8'hFF;
          ptr     <= ptr + 6'd1;
        end else begin
          TX_BYTE <= 8'hFF;
        end
`endif
      end
      // Bus conditions apply after the byte, so they override DISCARD.
      if (I2C_STOP)       state <= IDLE;
      else if (I2C_START) state <= ACTIVE;
    end
  end

endmodule
